// File: rtl/cache_ctrl_pkg.sv
// Shared types and sizing helpers for the per-set cache controller.
package cache_ctrl_pkg;

    // Fallback geometry used when the parent does not override the parameters.
    localparam int DEF_TAG_WIDTH    = 20;
    localparam int DEF_OFFSET_WIDTH = 6;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WRITEBACK = 2'd1,
        REFILL    = 2'd2
    } state_t;

    // Number of 32-bit words in a line for a given byte-offset width.
    function automatic int line_size(input int offset_width);
        return 2 ** (offset_width - 2);
    endfunction

    // Width of a way index; a set always has at least two ways.
    function automatic int way_bits(input int ways);
        return (ways > 1) ? $clog2(ways) : 1;
    endfunction

endpackage

// File: rtl/cache_ctrl_victim_sel.sv
// Victim choice for a miss: the lowest invalid way, or the round-robin way
// when every way already holds a valid line.
module cache_ctrl_victim_sel
    import cache_ctrl_pkg::*;
#(
    parameter int SET_WAYS = 4,
    parameter int WAY_W    = way_bits(SET_WAYS)
) (
    input  logic [SET_WAYS-1:0] valid,
    input  logic [WAY_W-1:0]    rr,
    output logic [WAY_W-1:0]    victim,
    output logic                all_valid
);

    // Scan from the top down so the lowest invalid way wins.
    always_comb begin
        all_valid = &valid;
        victim    = rr;
        for (int i = SET_WAYS - 1; i >= 0; i--) begin
            if (!valid[i]) begin
                victim = WAY_W'(i);
            end
        end
    end

endmodule

// File: rtl/cache_ctrl.sv
// Per-set cache controller: serves hits in the request cycle and, on a miss,
// writes back a dirty victim and refills it one word per memory handshake.
module cache_ctrl
    import cache_ctrl_pkg::*;
#(
    parameter int TAG_WIDTH    = DEF_TAG_WIDTH,
    parameter int OFFSET_WIDTH = DEF_OFFSET_WIDTH,
    parameter int SET_WAYS     = 4
) (
    input  logic                                clk_i,
    input  logic                                rst_i,
    input  logic                                cpu_req_i,
    input  logic                                cpu_we_i,
    input  logic [TAG_WIDTH-1:0]                cpu_tag_i,
    input  logic [OFFSET_WIDTH-3:0]             cpu_offset_i,
    input  logic [31:0]                         cpu_wdata_i,
    output logic [31:0]                         cpu_rdata_o,
    output logic                                cpu_ready_o,
    output logic                                mem_req_o,
    output logic                                mem_we_o,
    output logic [TAG_WIDTH-1:0]                mem_tag_o,
    output logic [OFFSET_WIDTH-3:0]             mem_offset_o,
    output logic [31:0]                         mem_wdata_o,
    input  logic [31:0]                         mem_rdata_i,
    input  logic                                mem_ready_i,
    output logic [SET_WAYS-1:0]                 line_we_o,
    output logic                                line_valid_o,
    output logic                                line_dirty_o,
    output logic [TAG_WIDTH-1:0]                line_tag_o,
    output logic [OFFSET_WIDTH-3:0]             line_offset_o,
    output logic [31:0]                         line_wdata_o,
    input  logic [SET_WAYS-1:0]                 line_hit_i,
    input  logic [SET_WAYS-1:0]                 line_valid_i,
    input  logic [SET_WAYS-1:0]                 line_dirty_i,
    input  logic [SET_WAYS-1:0][TAG_WIDTH-1:0]  line_tag_i,
    input  logic [SET_WAYS-1:0][31:0]           line_rdata_i
);

    localparam int LINE_SIZE = line_size(OFFSET_WIDTH);
    localparam int WORD_W    = OFFSET_WIDTH - 2;
    localparam int WAY_W     = way_bits(SET_WAYS);

    localparam logic [WORD_W-1:0] LAST_WORD = WORD_W'(LINE_SIZE - 1);
    localparam logic [WAY_W-1:0]  LAST_WAY  = WAY_W'(SET_WAYS - 1);

    state_t            state;
    logic [WORD_W-1:0] cnt;
    logic [WAY_W-1:0]  vic;
    logic [WAY_W-1:0]  rr;

    logic [WAY_W-1:0]  sel_way;
    logic              all_valid;
    logic [WAY_W-1:0]  hit_way;
    logic              hit;
    logic              miss;
    logic              last_word;
    logic              sel_dirty;

    cache_ctrl_victim_sel #(
        .SET_WAYS (SET_WAYS),
        .WAY_W    (WAY_W)
    ) u_victim_sel (
        .valid     (line_valid_i),
        .rr        (rr),
        .victim    (sel_way),
        .all_valid (all_valid)
    );

    // Lowest hitting way; tags are unique per set, so this only matters as a tie-break.
    always_comb begin
        hit_way = '0;
        for (int i = SET_WAYS - 1; i >= 0; i--) begin
            if (line_hit_i[i]) begin
                hit_way = WAY_W'(i);
            end
        end
    end

    assign hit       = cpu_req_i & (|line_hit_i);
    assign miss      = cpu_req_i & ~(|line_hit_i);
    assign last_word = (cnt == LAST_WORD);
    assign sel_dirty = line_valid_i[sel_way] & line_dirty_i[sel_way];

    // Sequencer: latch the victim on a miss, then step one word per memory handshake.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= IDLE;
            cnt   <= '0;
            vic   <= '0;
            rr    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (miss) begin
                        vic <= sel_way;
                        cnt <= '0;
                        if (all_valid) begin
                            rr <= (rr == LAST_WAY) ? '0 : rr + 1'b1;
                        end
                        state <= sel_dirty ? WRITEBACK : REFILL;
                    end
                end
                WRITEBACK: begin
                    if (mem_ready_i) begin
                        if (last_word) begin
                            cnt   <= '0;
                            state <= REFILL;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                REFILL: begin
                    if (mem_ready_i) begin
                        cnt <= cnt + 1'b1;
                        if (last_word) begin
                            state <= IDLE;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Mealy outputs: hit service in IDLE, memory transfer and line writes during a miss.
    always_comb begin
        cpu_ready_o   = 1'b0;
        cpu_rdata_o   = '0;
        mem_req_o     = 1'b0;
        mem_we_o      = 1'b0;
        mem_tag_o     = '0;
        mem_offset_o  = '0;
        mem_wdata_o   = '0;
        line_we_o     = '0;
        line_valid_o  = 1'b0;
        line_dirty_o  = 1'b0;
        line_tag_o    = cpu_tag_i;
        line_offset_o = cnt;
        line_wdata_o  = '0;
        case (state)
            IDLE: begin
                line_offset_o = cpu_offset_i;
                if (hit) begin
                    cpu_ready_o = 1'b1;
                    if (cpu_we_i) begin
                        line_we_o[hit_way] = 1'b1;
                        line_valid_o       = 1'b1;
                        line_dirty_o       = 1'b1;
                        line_wdata_o       = cpu_wdata_i;
                    end else begin
                        cpu_rdata_o = line_rdata_i[hit_way];
                    end
                end
            end
            WRITEBACK: begin
                line_tag_o   = line_tag_i[vic];
                mem_req_o    = 1'b1;
                mem_we_o     = 1'b1;
                mem_tag_o    = line_tag_i[vic];
                mem_offset_o = cnt;
                mem_wdata_o  = line_rdata_i[vic];
            end
            REFILL: begin
                mem_req_o    = 1'b1;
                mem_tag_o    = cpu_tag_i;
                mem_offset_o = cnt;
                if (mem_ready_i) begin
                    // The line only becomes valid with its final word, so an
                    // aborted refill can never produce a hit on partial data.
                    line_we_o[vic] = 1'b1;
                    line_wdata_o   = mem_rdata_i;
                    line_valid_o   = last_word;
                end
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_cache_ctrl.sv
// Bench for cache_ctrl with two ways of four words. The line storage and the
// memory are modelled here; read data, writeback words and refill words are
// predicted into queues when a request is issued and checked as they appear.
module tb_cache_ctrl;

    localparam int TW = 8;
    localparam int OW = 4;
    localparam int NW = 2;
    localparam int LS = 4;

    logic               clk = 1'b0;
    logic               rst;
    logic               cpu_req;
    logic               cpu_we;
    logic [TW-1:0]      cpu_tag;
    logic [OW-3:0]      cpu_offset;
    logic [31:0]        cpu_wdata;
    logic [31:0]        cpu_rdata;
    logic               cpu_ready;
    logic               mem_req;
    logic               mem_we;
    logic [TW-1:0]      mem_tag;
    logic [OW-3:0]      mem_offset;
    logic [31:0]        mem_wdata;
    logic [31:0]        mem_rdata;
    logic               mem_ready;
    logic [NW-1:0]      line_we;
    logic               line_valid_w;
    logic               line_dirty_w;
    logic [TW-1:0]      line_tag_w;
    logic [OW-3:0]      line_offset;
    logic [31:0]        line_wdata;
    logic [NW-1:0]      line_hit;
    logic [NW-1:0]      line_valid_r;
    logic [NW-1:0]      line_dirty_r;
    logic [NW-1:0][TW-1:0] line_tag_r;
    logic [NW-1:0][31:0]   line_rdata;

    logic               mem_en;
    logic               ln_clr;
    logic               ln_valid [NW];
    logic               ln_dirty [NW];
    logic [TW-1:0]      ln_tag   [NW];
    logic [31:0]        ln_data  [NW][LS];

    int errors = 0;
    int checks = 0;

    logic [31:0] exp_rd [$];
    logic [41:0] exp_wb [$];
    logic [11:0] exp_rf [$];

    always #5 clk = ~clk;

    cache_ctrl #(
        .TAG_WIDTH    (TW),
        .OFFSET_WIDTH (OW),
        .SET_WAYS     (NW)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .cpu_req_i     (cpu_req),
        .cpu_we_i      (cpu_we),
        .cpu_tag_i     (cpu_tag),
        .cpu_offset_i  (cpu_offset),
        .cpu_wdata_i   (cpu_wdata),
        .cpu_rdata_o   (cpu_rdata),
        .cpu_ready_o   (cpu_ready),
        .mem_req_o     (mem_req),
        .mem_we_o      (mem_we),
        .mem_tag_o     (mem_tag),
        .mem_offset_o  (mem_offset),
        .mem_wdata_o   (mem_wdata),
        .mem_rdata_i   (mem_rdata),
        .mem_ready_i   (mem_ready),
        .line_we_o     (line_we),
        .line_valid_o  (line_valid_w),
        .line_dirty_o  (line_dirty_w),
        .line_tag_o    (line_tag_w),
        .line_offset_o (line_offset),
        .line_wdata_o  (line_wdata),
        .line_hit_i    (line_hit),
        .line_valid_i  (line_valid_r),
        .line_dirty_i  (line_dirty_r),
        .line_tag_i    (line_tag_r),
        .line_rdata_i  (line_rdata)
    );

    // Memory contents: a recognisable word per (tag, offset).
    function automatic logic [31:0] mw(input logic [TW-1:0] tag, input logic [OW-3:0] off);
        return {16'hC0DE, tag, 6'b0, off};
    endfunction

    assign mem_ready = mem_en & mem_req;
    assign mem_rdata = mw(mem_tag, mem_offset);

    // Line model read side.
    always_comb begin
        for (int w = 0; w < NW; w++) begin
            line_hit[w]     = ln_valid[w] && (ln_tag[w] == line_tag_w);
            line_valid_r[w] = ln_valid[w];
            line_dirty_r[w] = ln_dirty[w];
            line_tag_r[w]   = ln_tag[w];
            line_rdata[w]   = ln_data[w][line_offset];
        end
    end

    // Line model write side.
    always @(posedge clk) begin
        for (int w = 0; w < NW; w++) begin
            if (ln_clr) begin
                ln_valid[w] <= 1'b0;
                ln_dirty[w] <= 1'b0;
                ln_tag[w]   <= '0;
                for (int k = 0; k < LS; k++) ln_data[w][k] <= '0;
            end else if (line_we[w]) begin
                ln_data[w][line_offset] <= line_wdata;
                ln_valid[w]             <= line_valid_w;
                ln_dirty[w]             <= line_dirty_w;
                ln_tag[w]               <= line_tag_w;
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push_refill(input logic [NW-1:0] way, input logic [TW-1:0] tag);
        for (int k = 0; k < LS; k++) exp_rf.push_back({way, tag, 2'(k)});
    endtask

    // Monitor: compare every produced result against the head of its queue.
    always @(negedge clk) begin
        logic [31:0] er;
        logic [41:0] ew;
        logic [11:0] ef;
        if (!rst) begin
            if (cpu_ready && !cpu_we) begin
                if (exp_rd.size() == 0) chk("rd_unexpected", {32'd0, cpu_rdata}, 64'hFFFF_FFFF_FFFF_FFFF);
                else begin
                    er = exp_rd.pop_front();
                    chk("rd_data", {32'd0, cpu_rdata}, {32'd0, er});
                end
            end
            if (mem_req && mem_ready && mem_we) begin
                if (exp_wb.size() == 0) chk("wb_unexpected", {22'd0, mem_tag, mem_offset, mem_wdata}, 64'hFFFF_FFFF_FFFF_FFFF);
                else begin
                    ew = exp_wb.pop_front();
                    chk("wb_word", {20'd0, line_we, mem_tag, mem_offset, mem_wdata}, {20'd0, 2'b00, ew});
                end
            end
            if (mem_req && mem_ready && !mem_we) begin
                if (exp_rf.size() == 0) chk("rf_unexpected", {52'd0, line_we, mem_tag, mem_offset}, 64'hFFFF_FFFF_FFFF_FFFF);
                else begin
                    ef = exp_rf.pop_front();
                    chk("rf_ctrl",
                        {40'd0, line_we, mem_tag, mem_offset, line_offset, line_tag_w, line_valid_w, line_dirty_w},
                        {40'd0, ef[11:10], ef[9:2], ef[1:0], ef[1:0], ef[9:2], (ef[1:0] == 2'd3), 1'b0});
                    chk("rf_wdata", {32'd0, line_wdata}, {32'd0, mw(ef[9:2], ef[1:0])});
                end
            end
        end
    end

    // Issue one CPU request, hold it until cpu_ready_o, report wait cycles.
    task automatic access(input logic we, input logic [TW-1:0] tag, input logic [OW-3:0] off,
                          input logic [31:0] wd, output int lat, output logic [NW-1:0] we_seen);
        logic done;
        cpu_req    = 1'b1;
        cpu_we     = we;
        cpu_tag    = tag;
        cpu_offset = off;
        cpu_wdata  = wd;
        lat        = 0;
        we_seen    = '0;
        done       = 1'b0;
        while (!done) begin
            @(negedge clk);
            if (cpu_ready) begin
                done    = 1'b1;
                we_seen = line_we;
            end else begin
                lat++;
                if (lat >= 200) begin
                    chk("cpu_ready_timeout", {63'd0, cpu_ready}, 64'd1);
                    done = 1'b1;
                end
            end
        end
        @(posedge clk);
        #1 cpu_req = 1'b0;
    endtask

    int          lat;
    logic [NW-1:0] wes;

    initial begin
        rst        = 1'b1;
        ln_clr     = 1'b1;
        mem_en     = 1'b1;
        cpu_req    = 1'b0;
        cpu_we     = 1'b0;
        cpu_tag    = '0;
        cpu_offset = '0;
        cpu_wdata  = '0;
        repeat (2) @(posedge clk);
        #1 ln_clr = 1'b0;
        chk("rst_ctrl", {60'd0, mem_req, mem_we, cpu_ready, |line_we}, 64'd0);
        chk("rst_rdata", {32'd0, cpu_rdata}, 64'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        #1 chk("idle_ctrl", {60'd0, mem_req, mem_we, cpu_ready, |line_we}, 64'd0);
        chk("idle_mem", {mem_tag, mem_offset, mem_wdata}, 64'd0);
        @(posedge clk);
        #1;

        // Cold miss: refill into way 0.
        push_refill(2'b01, 8'h05);
        exp_rd.push_back(mw(8'h05, 2'd1));
        access(1'b0, 8'h05, 2'd1, 32'd0, lat, wes);
        chk("cold_miss_lat", lat, 5);

        // Write hit: same cycle, way 0.
        access(1'b1, 8'h05, 2'd2, 32'hDEADBEEF, lat, wes);
        chk("wr_hit_lat", lat, 0);
        chk("wr_hit_we", wes, 2'b01);

        exp_rd.push_back(32'hDEADBEEF);
        access(1'b0, 8'h05, 2'd2, 32'd0, lat, wes);
        chk("rd_hit_lat", lat, 0);

        // Second way fills from invalid.
        push_refill(2'b10, 8'h06);
        exp_rd.push_back(mw(8'h06, 2'd0));
        access(1'b0, 8'h06, 2'd0, 32'd0, lat, wes);
        chk("fill_way1_lat", lat, 5);

        // All valid, rr=0, way 0 dirty: writeback then refill.
        exp_wb.push_back({8'h05, 2'd0, mw(8'h05, 2'd0)});
        exp_wb.push_back({8'h05, 2'd1, mw(8'h05, 2'd1)});
        exp_wb.push_back({8'h05, 2'd2, 32'hDEADBEEF});
        exp_wb.push_back({8'h05, 2'd3, mw(8'h05, 2'd3)});
        push_refill(2'b01, 8'h07);
        exp_rd.push_back(mw(8'h07, 2'd3));
        access(1'b0, 8'h07, 2'd3, 32'd0, lat, wes);
        chk("wb_miss_lat", lat, 9);

        // rr=1, way 1 clean: direct refill.
        push_refill(2'b10, 8'h08);
        exp_rd.push_back(mw(8'h08, 2'd1));
        access(1'b0, 8'h08, 2'd1, 32'd0, lat, wes);
        chk("clean_miss_lat", lat, 5);

        // rr wrapped to 0.
        push_refill(2'b01, 8'h09);
        exp_rd.push_back(mw(8'h09, 2'd2));
        access(1'b0, 8'h09, 2'd2, 32'd0, lat, wes);
        chk("rr_wrap_lat", lat, 5);

        // Memory stall for 10 cycles inside REFILL (victim way 1).
        push_refill(2'b10, 8'h0A);
        exp_rd.push_back(mw(8'h0A, 2'd0));
        mem_en = 1'b0;
        fork
            access(1'b0, 8'h0A, 2'd0, 32'd0, lat, wes);
            begin
                @(negedge clk);
                for (int c = 0; c < 10; c++) begin
                    @(negedge clk);
                    chk("stall_hold", {56'd0, mem_req, mem_we, line_we, mem_offset, 2'b00},
                        {56'd0, 1'b1, 1'b0, 2'b00, 2'd0, 2'b00});
                end
                @(posedge clk);
                #1 mem_en = 1'b1;
            end
        join
        chk("stall_lat", lat, 15);

        // Reset at cnt=2 of a refill into way 0, then the held request refills again.
        exp_rf.push_back({2'b01, 8'h0B, 2'd0});
        exp_rf.push_back({2'b01, 8'h0B, 2'd1});
        push_refill(2'b01, 8'h0B);
        exp_rd.push_back(mw(8'h0B, 2'd1));
        fork
            access(1'b0, 8'h0B, 2'd1, 32'd0, lat, wes);
            begin
                repeat (3) @(negedge clk);
                @(posedge clk);
                #2 chk("pre_rst_refill", {61'd0, mem_req, mem_offset}, {61'd0, 1'b1, 2'd2});
                rst = 1'b1;
                #1 chk("rst_mid_miss", {62'd0, mem_req, |line_we}, 64'd0);
                @(posedge clk);
                #1 rst = 1'b0;
            end
        join
        chk("rst_rerefill_lat", lat, 9);

        exp_rd.push_back(mw(8'h0B, 2'd1));
        access(1'b0, 8'h0B, 2'd1, 32'd0, lat, wes);
        chk("after_rst_hit_lat", lat, 0);

        repeat (2) @(posedge clk);
        chk("rd_queue_left", exp_rd.size(), 0);
        chk("wb_queue_left", exp_wb.size(), 0);
        chk("rf_queue_left", exp_rf.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
